// File: rtl/reg_file_nrp.sv
// reg_file_nrp: DEPTH x WIDTH register file with prioritized clear, parallel
// load and masked single-register write. Each register has a dirty flag.
// The file has NRP combinational read ports. Each port can optionally show
// the value its register will hold after the next clock edge.
module reg_file_nrp #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int NRP    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr_en,
  input  logic                     load_en,
  input  logic [DEPTH*WIDTH-1:0]   load_data,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [WIDTH-1:0]         wr_mask,
  input  logic [NRP*AW-1:0]        rd_addr,
  output logic [NRP*WIDTH-1:0]     rd_data,
  input  logic [DEPTH-1:0]         dirty_clr,
  output logic [DEPTH-1:0]         dirty
);

  // One extra bit lets an address be compared against DEPTH itself.
  // This matters when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] dirty_q;
  logic [DEPTH-1:0] dirty_d;

  logic wr_ok;
  logic mask_any;

  // A write only counts when no higher-priority command is active and the
  // address names a real register.
  always_comb begin
    wr_ok    = wr_en && !clr_en && !load_en && ({1'b0, wr_addr} < DEPTH_W);
    mask_any = |wr_mask;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [AW-1:0] IDX = AW'(gi);
      logic [WIDTH-1:0] reg_nx;
      logic             dirty_nx;

      // Next value of this register and its dirty flag.
      // Priority is clear, then load, then write.
      // A write that sets the flag overrides a dirty_clr on the same edge.
      always_comb begin
        reg_nx   = regs_q[gi];
        dirty_nx = dirty_q[gi] & ~dirty_clr[gi];
        if (clr_en) begin
          reg_nx   = '0;
          dirty_nx = 1'b0;
        end else if (load_en) begin
          reg_nx   = load_data[(DEPTH-1-gi)*WIDTH +: WIDTH];
          dirty_nx = 1'b0;
        end else if (wr_ok && (wr_addr == IDX)) begin
          reg_nx = (regs_q[gi] & ~wr_mask) | (wr_data & wr_mask);
          if (mask_any) begin
            dirty_nx = 1'b1;
          end
        end
      end

      assign regs_d[gi]  = reg_nx;
      assign dirty_d[gi] = dirty_nx;
    end
  endgenerate

  // State registers. Reset clears everything immediately.
  // Any command pending at that moment is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      dirty_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      dirty_q <= dirty_d;
    end
  end

  generate
    for (gi = 0; gi < NRP; gi++) begin : g_rd
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] rv;

      assign ra = rd_addr[gi*AW +: AW];

      // Combinational read. An out-of-range address reads 0.
      // So does any read while reset is held.
      // In bypass mode the port shows the value this register will hold
      // after the next edge.
      always_comb begin
        rv = '0;
        if (!reset && ({1'b0, ra} < DEPTH_W)) begin
          if (BYPASS != 0) begin
            rv = regs_d[ra];
          end else begin
            rv = regs_q[ra];
          end
        end
      end

      assign rd_data[gi*WIDTH +: WIDTH] = rv;
    end
  endgenerate

  assign dirty = dirty_q;

endmodule

// File: tb/tb_reg_file_nrp.sv
// Testbench for reg_file_nrp with three instances:
//   u0: DEPTH=4, BYPASS=0
//   u1: DEPTH=4, BYPASS=1
//   u2: DEPTH=5, BYPASS=0
// u0 and u1 share their inputs.
// Stimulus pushes expected values into a queue.
// A monitor process pops each entry and compares it against the DUT.
module tb_reg_file_nrp;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // shared stimulus for u0/u1 (DEPTH=4, AW=2)
  logic        clr_en = 0, load_en = 0, wr_en = 0;
  logic [63:0] load_data = '0;
  logic [1:0]  wr_addr = '0;
  logic [15:0] wr_data = '0, wr_mask = '0;
  logic [3:0]  rd_addr = '0;
  logic [3:0]  dirty_clr = '0;
  logic [31:0] rd0, rd1;
  logic [3:0]  dirty0, dirty1;

  // stimulus for u2 (DEPTH=5, AW=3)
  logic        c_clr = 0, c_load = 0, c_wr_en = 0;
  logic [79:0] c_load_data = '0;
  logic [2:0]  c_wr_addr = '0;
  logic [15:0] c_wr_data = '0, c_wr_mask = '0;
  logic [5:0]  c_rd_addr = '0;
  logic [4:0]  c_dirty_clr = '0;
  logic [31:0] c_rd;
  logic [4:0]  c_dirty;

  always #5 clock = ~clock;

  reg_file_nrp #(.WIDTH(16), .DEPTH(4), .NRP(2), .BYPASS(0)) u0 (
    .clock(clock), .reset(reset), .clr_en(clr_en), .load_en(load_en),
    .load_data(load_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .rd_addr(rd_addr),
    .rd_data(rd0), .dirty_clr(dirty_clr), .dirty(dirty0));

  reg_file_nrp #(.WIDTH(16), .DEPTH(4), .NRP(2), .BYPASS(1)) u1 (
    .clock(clock), .reset(reset), .clr_en(clr_en), .load_en(load_en),
    .load_data(load_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .rd_addr(rd_addr),
    .rd_data(rd1), .dirty_clr(dirty_clr), .dirty(dirty1));

  reg_file_nrp #(.WIDTH(16), .DEPTH(5), .NRP(2), .BYPASS(0)) u2 (
    .clock(clock), .reset(reset), .clr_en(c_clr), .load_en(c_load),
    .load_data(c_load_data), .wr_en(c_wr_en), .wr_addr(c_wr_addr),
    .wr_data(c_wr_data), .wr_mask(c_wr_mask), .rd_addr(c_rd_addr),
    .rd_data(c_rd), .dirty_clr(c_dirty_clr), .dirty(c_dirty));

  // selectors of observed outputs
  localparam int S0P0 = 0, S0P1 = 1, S0D = 2, S1P0 = 3, S1P1 = 4, S1D = 5,
                 S2P0 = 6, S2P1 = 7, S2D = 8;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } item_t;

  item_t sbq[$];
  int    checks   = 0;
  int    failures = 0;
  event  chk_ev;

  function automatic logic [63:0] actual(input int sel);
    logic [63:0] v;
    v = '0;
    case (sel)
      S0P0: v = {48'd0, rd0[15:0]};
      S0P1: v = {48'd0, rd0[31:16]};
      S0D:  v = {60'd0, dirty0};
      S1P0: v = {48'd0, rd1[15:0]};
      S1P1: v = {48'd0, rd1[31:16]};
      S1D:  v = {60'd0, dirty1};
      S2P0: v = {48'd0, c_rd[15:0]};
      S2P1: v = {48'd0, c_rd[31:16]};
      S2D:  v = {59'd0, c_dirty};
      default: v = '1;
    endcase
    return v;
  endfunction

  // monitor: drains the scoreboard each time stimulus presents a sample point
  initial begin
    item_t       it;
    logic [63:0] act;
    forever begin
      @(chk_ev);
      while (sbq.size() > 0) begin
        it  = sbq.pop_front();
        act = actual(it.sel);
        checks++;
        if (act !== it.exp) begin
          failures++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end else begin
          $display("ok   %s: %h", it.name, act);
        end
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [63:0] exp);
    item_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    sbq.push_back(it);
  endtask

  // let combinational outputs settle, then hand the queued items to the monitor
  task automatic check_now();
    #1;
    -> chk_ev;
    #1;
  endtask

  task automatic idle();
    clr_en = 0; load_en = 0; wr_en = 0; dirty_clr = '0;
    c_clr = 0; c_load = 0; c_wr_en = 0; c_dirty_clr = '0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic [15:0] m);
    wr_en = 1; wr_addr = a; wr_data = d; wr_mask = m;
  endtask

  task automatic cwr(input logic [2:0] a, input logic [15:0] d, input logic [15:0] m);
    c_wr_en = 1; c_wr_addr = a; c_wr_data = d; c_wr_mask = m;
  endtask

  initial begin
    // reset held with a pending write: everything reads 0
    #2;
    wr(2'd0, 16'hFFFF, 16'hFFFF);
    rd_addr = {2'd0, 2'd0};
    expect_val("rst_u0_p0", S0P0, 64'h0);
    expect_val("rst_u1_p0_bypass", S1P0, 64'h0);
    expect_val("rst_u1_dirty", S1D, 64'h0);
    check_now();
    @(posedge clock); #2;
    expect_val("rst_edge_u0_p0", S0P0, 64'h0);
    expect_val("rst_edge_u1_p0", S1P0, 64'h0);
    check_now();

    // release reset, first write sets dirty[0]
    @(negedge clock);
    reset = 0;
    wr(2'd0, 16'h00AA, 16'hFFFF);
    @(negedge clock); idle();
    expect_val("w0_reg0", S0P0, 64'h00AA);
    expect_val("w0_dirty", S0D, 64'h1);
    check_now();

    // parallel load; bypass port shows loaded values early
    @(negedge clock);
    load_en = 1; load_data = 64'h1111_2222_3333_4444; rd_addr = {2'd3, 2'd0};
    expect_val("load_pre_u0_p0", S0P0, 64'h00AA);
    expect_val("load_pre_u1_p0", S1P0, 64'h1111);
    expect_val("load_pre_u1_p1", S1P1, 64'h4444);
    check_now();
    @(negedge clock); idle();
    expect_val("load_reg0", S0P0, 64'h1111);
    expect_val("load_reg3", S0P1, 64'h4444);
    expect_val("load_dirty", S0D, 64'h0);
    check_now();
    rd_addr = {2'd2, 2'd1};
    expect_val("load_reg1", S0P0, 64'h2222);
    expect_val("load_reg2", S0P1, 64'h3333);
    check_now();

    // masked write to reg2
    @(negedge clock);
    wr(2'd2, 16'hABCD, 16'h00FF); rd_addr = {2'd2, 2'd2};
    expect_val("mw_pre_u0", S0P0, 64'h3333);
    expect_val("mw_pre_u1_p0", S1P0, 64'h33CD);
    expect_val("mw_pre_u1_p1", S1P1, 64'h33CD);
    check_now();
    @(negedge clock); idle();
    expect_val("mw_reg2", S0P0, 64'h33CD);
    expect_val("mw_dirty", S0D, 64'h4);
    check_now();

    // zero mask: no change, no dirty; dirty_clr[2] clears the flag
    @(negedge clock);
    wr(2'd2, 16'hABCD, 16'h0000); dirty_clr = 4'b0100;
    expect_val("m0_pre_u1", S1P0, 64'h33CD);
    check_now();
    @(negedge clock); idle();
    expect_val("m0_reg2", S0P0, 64'h33CD);
    expect_val("m0_dirty_u0", S0D, 64'h0);
    expect_val("m0_dirty_u1", S1D, 64'h0);
    check_now();

    // both ports on the same register during a full write
    @(negedge clock);
    wr(2'd1, 16'h5A5A, 16'hFFFF); rd_addr = {2'd1, 2'd1};
    expect_val("byp_u1_p0", S1P0, 64'h5A5A);
    expect_val("byp_u1_p1", S1P1, 64'h5A5A);
    expect_val("nobyp_u0_p0", S0P0, 64'h2222);
    expect_val("nobyp_u0_p1", S0P1, 64'h2222);
    check_now();
    @(negedge clock); idle();
    expect_val("byp_reg1", S0P0, 64'h5A5A);
    expect_val("byp_dirty", S0D, 64'h2);
    check_now();

    // dirty_clr on bits 1 and 2 while writing reg2: set wins on bit 2
    @(negedge clock);
    wr(2'd2, 16'h0001, 16'h000F); dirty_clr = 4'b0110; rd_addr = {2'd2, 2'd2};
    expect_val("setwin_pre_u1", S1P0, 64'h33C1);
    check_now();
    @(negedge clock); idle();
    expect_val("setwin_reg2", S0P0, 64'h33C1);
    expect_val("setwin_dirty_u0", S0D, 64'h4);
    expect_val("setwin_dirty_u1", S1D, 64'h4);
    check_now();

    // clear, load and write all at once: clear wins
    @(negedge clock);
    clr_en = 1; load_en = 1; load_data = 64'hDEAD_BEEF_CAFE_F00D;
    wr(2'd3, 16'hFFFF, 16'hFFFF); rd_addr = {2'd0, 2'd3};
    expect_val("clr_pre_u1_p0", S1P0, 64'h0);
    expect_val("clr_pre_u1_p1", S1P1, 64'h0);
    check_now();
    @(negedge clock); idle();
    expect_val("clr_reg3", S0P0, 64'h0);
    expect_val("clr_reg0", S0P1, 64'h0);
    expect_val("clr_dirty", S0D, 64'h0);
    check_now();

    // load and write together: load wins
    @(negedge clock);
    load_en = 1; load_data = 64'hAAAA_BBBB_CCCC_DDDD;
    wr(2'd0, 16'h1234, 16'hFFFF); rd_addr = {2'd3, 2'd0};
    expect_val("lw_pre_u1_p0", S1P0, 64'hAAAA);
    expect_val("lw_pre_u1_p1", S1P1, 64'hDDDD);
    check_now();
    @(negedge clock); idle();
    expect_val("lw_reg0", S0P0, 64'hAAAA);
    expect_val("lw_dirty", S0D, 64'h0);
    check_now();

    // DEPTH=5 instance: out-of-range addresses
    @(negedge clock);
    c_load = 1; c_load_data = 80'h0001_0002_0003_0004_0005; c_rd_addr = {3'd7, 3'd4};
    @(negedge clock); idle();
    expect_val("d5_reg4", S2P0, 64'h0005);
    expect_val("d5_rd7", S2P1, 64'h0);
    expect_val("d5_dirty0", S2D, 64'h0);
    check_now();
    cwr(3'd6, 16'hFFFF, 16'hFFFF); c_rd_addr = {3'd0, 3'd4};
    @(negedge clock); idle();
    cwr(3'd5, 16'hFFFF, 16'hFFFF);
    @(negedge clock); idle();
    expect_val("d5_w65_reg4", S2P0, 64'h0005);
    expect_val("d5_w65_reg0", S2P1, 64'h0001);
    expect_val("d5_w65_dirty", S2D, 64'h0);
    check_now();
    cwr(3'd4, 16'h00F0, 16'h00F0); c_rd_addr = {3'd6, 3'd4};
    @(negedge clock); idle();
    expect_val("d5_w4_reg4", S2P0, 64'h00F5);
    expect_val("d5_rd6", S2P1, 64'h0);
    expect_val("d5_w4_dirty", S2D, 64'h10);
    check_now();

    // async reset between edges while a write is pending
    @(negedge clock);
    wr(2'd1, 16'h7777, 16'hFFFF); rd_addr = {2'd1, 2'd1};
    expect_val("ar_pre_u0", S0P0, 64'hBBBB);
    expect_val("ar_pre_u1", S1P0, 64'h7777);
    check_now();
    reset = 1;
    expect_val("ar_now_u0", S0P0, 64'h0);
    expect_val("ar_now_u1", S1P0, 64'h0);
    expect_val("ar_now_u2", S2P0, 64'h0);
    check_now();
    @(posedge clock); #2;
    expect_val("ar_edge_u0", S0P0, 64'h0);
    expect_val("ar_edge_u1", S1P0, 64'h0);
    expect_val("ar_edge_dirty", S0D, 64'h0);
    check_now();
    @(negedge clock);
    reset = 0; idle();
    expect_val("ar_after_reg1", S0P0, 64'h0);
    check_now();

    #5;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
